// File: rtl/conv_pool_stream_if.sv
// rtl/conv_pool_stream_if.sv - input/output stream handshake bundle for conv_pool_stream
interface conv_pool_stream_if #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int ADDR_W = 16
);
  logic                     in_valid;
  logic signed [IN_W-1:0]   in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic [ADDR_W-1:0]        out_addr;
  logic [1:0]               history;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_addr, history
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_addr, history
  );
endinterface

// File: rtl/conv_pool_stream.sv
// rtl/conv_pool_stream.sv - raster conv-result stream, optional ReLU, 2x2 max/avg pool, scale and saturate
module conv_pool_stream #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 16,
  parameter int FMAP    = 16,
  parameter int RELU_EN = 1,
  parameter int SHIFT   = 0,
  parameter int ADDR_W  = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic mode_avg,
  conv_pool_stream_if.slave bus,
  output logic busy,
  output logic done
);
  localparam int HALF      = FMAP / 2;
  localparam int CW        = (FMAP > 2) ? $clog2(FMAP) : 1;
  localparam int HW        = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PW        = IN_W + 2;
  localparam int SW        = (PW > OUT_W) ? PW : OUT_W;
  localparam int LAST_ADDR = HALF * HALF - 1;
  localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_col, r_row;
  logic                    r_last_in;
  logic                    r_mode;
  logic signed [IN_W-1:0]  r_pair;
  logic signed [IN_W:0]    r_lb_val [HALF];
  logic                    r_lb_idx [HALF];
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_out_data;
  logic [ADDR_W-1:0]       r_out_addr;
  logic [ADDR_W-1:0]       r_addr_cnt;
  logic [1:0]              r_hist;

  logic                    w_in_ready, w_accept, w_produce, w_out_fire, w_start_frame;
  logic signed [IN_W-1:0]  w_x;
  logic signed [IN_W:0]    w_pair_val, w_top_val;
  logic                    w_pair_idx, w_top_idx;
  logic [HW-1:0]           w_lb_sel;
  logic signed [PW-1:0]    w_pooled;
  logic [1:0]              w_hist;
  logic signed [SW-1:0]    w_scaled;
  logic signed [OUT_W-1:0] w_sat;

  assign w_in_ready    = (r_state == S_RUN) & ~(r_out_valid & ~bus.out_ready) & ~r_last_in;
  assign w_accept      = bus.in_valid & w_in_ready;
  assign w_produce     = w_accept & r_row[0] & r_col[0];
  assign w_out_fire    = r_out_valid & bus.out_ready;
  assign w_start_frame = (r_state == S_IDLE) & start;
  assign w_lb_sel      = HW'(r_col >> 1);

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_addr  = r_out_addr;
  assign bus.history   = r_hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_out_fire && (r_out_addr == ADDR_W'(LAST_ADDR))) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Horizontal pair reduction; the left sample wins ties so the lower index is kept.
  always_comb begin
    w_x        = ((RELU_EN != 0) && (bus.in_data < 0)) ? '0 : bus.in_data;
    w_pair_val = '0;
    w_pair_idx = 1'b0;
    if (r_mode) begin
      w_pair_val = {r_pair[IN_W-1], r_pair} + {w_x[IN_W-1], w_x};
    end else if (w_x > r_pair) begin
      w_pair_val = {w_x[IN_W-1], w_x};
      w_pair_idx = 1'b1;
    end else begin
      w_pair_val = {r_pair[IN_W-1], r_pair};
    end
  end

  // Vertical combine with the buffered top pair, then scale and clamp.
  always_comb begin
    w_top_val = r_lb_val[w_lb_sel];
    w_top_idx = r_lb_idx[w_lb_sel];
    w_pooled  = '0;
    w_hist    = 2'd0;
    if (r_mode) begin
      w_pooled = (PW'(w_top_val) + PW'(w_pair_val)) >>> 2;
    end else if (w_pair_val > w_top_val) begin
      w_pooled = PW'(w_pair_val);
      w_hist   = {1'b1, w_pair_idx};
    end else begin
      w_pooled = PW'(w_top_val);
      w_hist   = {1'b0, w_top_idx};
    end
    w_scaled = SW'(w_pooled) >>> SHIFT;
    if (w_scaled > SAT_MAX)      w_sat = OUT_W'(SAT_MAX);
    else if (w_scaled < SAT_MIN) w_sat = OUT_W'(SAT_MIN);
    else                         w_sat = OUT_W'(w_scaled);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_last_in   <= 1'b0;
      r_mode      <= 1'b0;
      r_pair      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_addr_cnt  <= '0;
      r_hist      <= 2'd0;
      for (int i = 0; i < HALF; i++) begin
        r_lb_val[i] <= '0;
        r_lb_idx[i] <= 1'b0;
      end
    end else begin
      if (w_start_frame) begin
        r_col      <= '0;
        r_row      <= '0;
        r_last_in  <= 1'b0;
        r_addr_cnt <= '0;
        r_mode     <= mode_avg;
      end else if (w_accept) begin
        if (r_col == CW'(FMAP - 1)) begin
          r_col <= '0;
          if (r_row == CW'(FMAP - 1)) begin
            r_row     <= '0;
            r_last_in <= 1'b1;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (!r_col[0]) begin
          r_pair <= w_x;
        end else if (!r_row[0]) begin
          r_lb_val[w_lb_sel] <= w_pair_val;
          r_lb_idx[w_lb_sel] <= w_pair_idx;
        end
      end

      if (w_produce) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sat;
        r_out_addr  <= r_addr_cnt;
        r_hist      <= w_hist;
        r_addr_cnt  <= r_addr_cnt + 1'b1;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
        r_out_addr  <= '0;
        r_hist      <= 2'd0;
      end
    end
  end
endmodule

// File: tb/tb_conv_pool_stream.sv
// tb/tb_conv_pool_stream.sv - self-checking bench for conv_pool_stream
module tb_conv_pool_stream;
  localparam int FM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, st_a, st_b, mode, vld_a, vld_b, tb_ready, stall_arm;
  logic busy_a, done_a, busy_b, done_b;
  int   din, sel, total, bad, done_cnt_a, done_cnt_b;
  int   exp_d[$], exp_a[$], exp_h[$], cap_d[$], cap_h[$];

  conv_pool_stream_if #(.IN_W(16), .OUT_W(16), .ADDR_W(16)) ifa ();
  conv_pool_stream_if #(.IN_W(8),  .OUT_W(8),  .ADDR_W(16)) ifb ();

  assign ifa.in_valid  = vld_a;
  assign ifa.in_data   = din[15:0];
  assign ifa.out_ready = tb_ready;
  assign ifb.in_valid  = vld_b;
  assign ifb.in_data   = din[7:0];
  assign ifb.out_ready = tb_ready;

  conv_pool_stream #(.IN_W(16), .OUT_W(16), .FMAP(FM), .RELU_EN(1), .SHIFT(0), .ADDR_W(16)) dut_a (
    .clk(clk), .reset(rst), .start(st_a), .mode_avg(mode), .bus(ifa), .busy(busy_a), .done(done_a));
  conv_pool_stream #(.IN_W(8), .OUT_W(8), .FMAP(FM), .RELU_EN(0), .SHIFT(0), .ADDR_W(16)) dut_b (
    .clk(clk), .reset(rst), .start(st_b), .mode_avg(mode), .bus(ifb), .busy(busy_b), .done(done_b));

  logic w_rdy;
  assign w_rdy = (sel == 0) ? ifa.in_ready : ifb.in_ready;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each 2x2 window evaluated directly from the frame.
  task automatic model(input int pix[16], input bit avg, input bit relu, input int ow);
    int w[4];
    int best, sum, v, mx;
    mx = (1 << (ow - 1)) - 1;
    for (int r = 0; r < FM / 2; r++) begin
      for (int c = 0; c < FM / 2; c++) begin
        w[0] = pix[2*r*FM + 2*c];
        w[1] = pix[2*r*FM + 2*c + 1];
        w[2] = pix[(2*r+1)*FM + 2*c];
        w[3] = pix[(2*r+1)*FM + 2*c + 1];
        if (relu) for (int k = 0; k < 4; k++) if (w[k] < 0) w[k] = 0;
        best = 0;
        for (int k = 1; k < 4; k++) if (w[k] > w[best]) best = k;
        sum = w[0] + w[1] + w[2] + w[3];
        v = avg ? (sum >>> 2) : w[best];
        if (v > mx) v = mx;
        if (v < -mx - 1) v = -mx - 1;
        exp_d.push_back(v);
        exp_a.push_back(r * (FM / 2) + c);
        exp_h.push_back(avg ? 0 : best);
      end
    end
  endtask

  task automatic take(input int which, input int d, input int a, input int h);
    if (exp_d.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_output: dut %0d produced data %0d addr %0d, none expected", which, d, a);
    end else begin
      chk("out_data", d, exp_d.pop_front());
      chk("out_addr", a, exp_a.pop_front());
      chk("history", h, exp_h.pop_front());
      chk("dut_sel", which, sel);
      cap_d.push_back(d);
      cap_h.push_back(h);
    end
  endtask

  always @(negedge clk) begin
    if (ifa.out_valid && tb_ready) take(0, int'(ifa.out_data), int'(ifa.out_addr), int'(ifa.history));
    if (ifb.out_valid && tb_ready) take(1, int'(ifb.out_data), int'(ifb.out_addr), int'(ifb.history));
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  initial begin
    logic signed [15:0] hd;
    int ha;
    tb_ready  = 1'b1;
    stall_arm = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (stall_arm && ifa.out_valid) begin
        stall_arm = 1'b0;
        tb_ready  = 1'b0;
        hd = ifa.out_data;
        ha = int'(ifa.out_addr);
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("stall_in_ready", int'(ifa.in_ready), 0);
          chk("stall_out_valid", int'(ifa.out_valid), 1);
          chk("stall_out_data", int'(ifa.out_data), int'(hd));
          chk("stall_out_addr", int'(ifa.out_addr), ha);
          @(posedge clk);
          #2;
        end
        tb_ready = 1'b1;
      end
    end
  end

  task automatic run_frame(input int which, input bit avg, input int pix[16], input int nfeed,
                           input bit stall, input bit complete);
    int t, d0;
    sel = which;
    cap_d.delete();
    cap_h.delete();
    model(pix, avg, which == 0, (which == 0) ? 16 : 8);
    d0 = (which == 0) ? done_cnt_a : done_cnt_b;
    @(posedge clk); #1;
    if (which == 0) st_a = 1'b1; else st_b = 1'b1;
    mode = avg;
    @(posedge clk); #1;
    st_a = 1'b0;
    st_b = 1'b0;
    mode = ~avg;
    stall_arm = stall;
    for (int i = 0; i < nfeed; i++) begin
      if (i % 5 == 3) begin @(posedge clk); #1; end
      din = pix[i];
      if (which == 0) vld_a = 1'b1; else vld_b = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        if (w_rdy) begin
          @(posedge clk); #1;
          break;
        end
        @(posedge clk); #1;
        t++;
        if (t > 100) begin
          chk("accept_timeout", t, 0);
          break;
        end
      end
      vld_a = 1'b0;
      vld_b = 1'b0;
    end
    if (complete) begin
      t = 0;
      while (exp_d.size() > 0 && t < 200) begin @(posedge clk); t++; end
      repeat (4) @(posedge clk);
      #1;
      chk("queue_drained", exp_d.size(), 0);
      chk("done_pulses", ((which == 0) ? done_cnt_a : done_cnt_b) - d0, 1);
      chk("busy_after_frame", int'((which == 0) ? busy_a : busy_b), 0);
    end
  endtask

  initial begin
    int f1[16], f3[16], f4[16], f5[16];
    int l1[4], l2[4], l3d[4], l3h[4], l3bd[4], l3bh[4], l4[4];
    rst = 1'b1; st_a = 1'b0; st_b = 1'b0; mode = 1'b0; vld_a = 1'b0; vld_b = 1'b0;
    din = 0; sel = 0; total = 0; bad = 0; done_cnt_a = 0; done_cnt_b = 0;
    f1  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    f3  = '{-5, -3, 4, 9, -8, -1, 2, 1, 6, 6, -2, -7, 6, 6, -9, -7};
    f4  = '{127, 127, -128, -128, 127, 127, -128, -128, -1, -2, 1, 2, -3, -4, 3, 5};
    f5  = '{3, -1, 7, 7, 2, 8, 0, -4, 10, 11, 12, 13, 14, 15, 16, 17};
    l1  = '{5, 7, 13, 15};
    l2  = '{2, 4, 10, 12};
    l3d = '{0, 9, 6, 0};
    l3h = '{0, 1, 0, 0};
    l3bd = '{-1, 9, 6, -2};
    l3bh = '{3, 1, 0, 0};
    l4  = '{127, -128, -3, 2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(ifa.out_valid), 0);
    chk("rst_in_ready", int'(ifa.in_ready), 0);
    chk("rst_out_data", int'(ifa.out_data), 0);
    chk("rst_out_addr", int'(ifa.out_addr), 0);
    chk("rst_history", int'(ifa.history), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    rst = 1'b0;

    run_frame(0, 1'b0, f1, 16, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("t1_max_data", cap_d[k], l1[k]);
      chk("t1_max_hist", cap_h[k], 3);
    end

    run_frame(0, 1'b1, f1, 16, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("t2_avg_data", cap_d[k], l2[k]);
      chk("t2_avg_hist", cap_h[k], 0);
    end

    run_frame(0, 1'b0, f3, 16, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("t3_relu_data", cap_d[k], l3d[k]);
      chk("t3_relu_hist", cap_h[k], l3h[k]);
    end

    run_frame(1, 1'b0, f3, 16, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("t3b_neg_max_data", cap_d[k], l3bd[k]);
      chk("t3b_neg_max_hist", cap_h[k], l3bh[k]);
    end

    run_frame(1, 1'b1, f4, 16, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) chk("t4_avg8_data", cap_d[k], l4[k]);

    run_frame(0, 1'b0, f5, 16, 1'b1, 1'b1);

    run_frame(0, 1'b1, f1, 6, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", int'(busy_a), 0);
    chk("midrst_out_valid", int'(ifa.out_valid), 0);
    chk("midrst_in_ready", int'(ifa.in_ready), 0);
    chk("midrst_partial_out", cap_d[0], 2);
    chk("midrst_pending", exp_d.size(), 3);
    exp_d.delete();
    exp_a.delete();
    exp_h.delete();
    rst = 1'b0;
    run_frame(0, 1'b0, f5, 16, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
